// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: size codes, FIFO entry layout and the
// byte-enable helper used by the lane formatter.
package store_buffer_pkg;

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_BYTE  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam int unsigned MAX_ADDR_W = 64;
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MAX_NB     = MAX_DATA_W / 8;

    // Entries are sized for the widest legal bus; narrower builds zero-extend into them.
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_NB-1:0]     be;
    } sb_entry_t;

    function automatic logic [MAX_NB-1:0] be_mask(input logic [1:0] size, input logic [2:0] ofs);
        logic [MAX_NB-1:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0f;
            default: base = 8'hff;
        endcase
        return base << ofs;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store formatter: moves right-justified register data onto byte lanes,
// builds the byte-enable mask and flags misaligned or illegal-size stores.
module store_lane_align
    import store_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB    = DATA_W / 8,
    localparam int unsigned OFS_W = $clog2(NB)
) (
    input  logic [OFS_W-1:0]  ofs_i,
    input  logic [1:0]        size_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] lane_data_o,
    output logic [NB-1:0]     be_o,
    output logic              misalign_o
);

    logic [MAX_NB-1:0] be_full;
    logic [DATA_W-1:0] shifted;
    logic              unused_be;

    assign be_full   = be_mask(size_i, 3'(ofs_i));
    assign be_o      = be_full[NB-1:0];
    assign unused_be = ^be_full;
    assign shifted   = data_i << {ofs_i, 3'b000};

    // Lanes outside the enable window carry zero so upper register bits never leak.
    always_comb begin
        lane_data_o = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (be_o[i]) begin
                lane_data_o[8*i +: 8] = shifted[8*i +: 8];
            end
        end
    end

    always_comb begin
        unique case (size_i)
            SZ_BYTE: misalign_o = 1'b0;
            SZ_HALF: misalign_o = ofs_i[0];
            SZ_WORD: misalign_o = |ofs_i[1:0];
            default: misalign_o = (DATA_W != 64) || (|ofs_i);
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: lane formatting, DEPTH-entry FIFO and
// valid/ready drain. Define STORE_BUF_MERGE_EN to enable write combining.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_data,
    input  logic [1:0]             st_size,
    output logic                   st_misalign,
    output logic [ADDR_W-1:0]      st_bad_addr,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [DATA_W/8-1:0]    mem_be,
    output logic                   sb_empty,
    output logic [$clog2(DEPTH):0] sb_count
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFS_W = $clog2(NB);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("store_buffer: DATA_W must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("store_buffer: DEPTH must be a power of two >= 2");
    end

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q;
    logic [ADDR_W-1:0] bad_addr_q;

    logic [DATA_W-1:0] lane_data;
    logic [NB-1:0]     lane_be;
    logic              lane_misalign;
    logic [ADDR_W-1:0] st_addr_al;
    logic              full;
    logic              accept;
    logic              do_enq;
    logic              do_deq;
    logic              merge_hit;
    sb_entry_t         head;
    logic              unused_head;

    store_lane_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .ofs_i      (st_addr[OFS_W-1:0]),
        .size_i     (st_size),
        .data_i     (st_data),
        .lane_data_o(lane_data),
        .be_o       (lane_be),
        .misalign_o (lane_misalign)
    );

    assign st_addr_al = {st_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign full       = (count_q == CNT_FULL);
    assign mem_valid  = (count_q != '0);
    assign sb_empty   = !mem_valid;
    assign sb_count   = count_q;

`ifdef STORE_BUF_MERGE_EN
    logic [PTR_W-1:0] young_idx;
    logic             do_merge;

    assign young_idx = tail_q - PTR_W'(1);
    // With fewer than two entries the youngest is the head, which memory may be reading.
    assign merge_hit = (count_q >= CNT_W'(2)) && !lane_misalign &&
                       (mem_q[young_idx].addr == MAX_ADDR_W'(st_addr_al));
    assign st_ready  = !full || merge_hit;
    assign do_merge  = accept && merge_hit;
`else
    assign merge_hit = 1'b0;
    assign st_ready  = !full;
`endif

    assign accept = st_valid && st_ready;
    assign do_enq = accept && !lane_misalign && !merge_hit;
    assign do_deq = mem_valid && mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_enq) tail_d = tail_q + PTR_W'(1);
        if (do_deq) head_d = head_q + PTR_W'(1);
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= accept && lane_misalign;
            if (accept && lane_misalign) begin
                bad_addr_q <= st_addr;
            end
        end
    end

    // Entry storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_q[tail_q] <= '{addr: MAX_ADDR_W'(st_addr_al),
                               data: MAX_DATA_W'(lane_data),
                               be:   MAX_NB'(lane_be)};
        end
`ifdef STORE_BUF_MERGE_EN
        else if (do_merge) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (lane_be[i]) begin
                    mem_q[young_idx].data[8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
            mem_q[young_idx].be <= mem_q[young_idx].be | MAX_NB'(lane_be);
        end
`endif
    end

    assign head        = mem_q[head_q];
    assign unused_head = ^head;
    assign mem_addr    = mem_valid ? head.addr[ADDR_W-1:0] : '0;
    assign mem_wdata   = mem_valid ? head.data[DATA_W-1:0] : '0;
    assign mem_be      = mem_valid ? head.be[NB-1:0]       : '0;

    assign st_misalign = misalign_q;
    assign st_bad_addr = bad_addr_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model for a 32-bit instance
// plus directed checks on a 64-bit instance. Honours STORE_BUF_MERGE_EN.
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STORE_BUF_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        st_misalign;
    logic [31:0] st_bad_addr;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        sb_empty;
    logic [2:0]  sb_count;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [31:0] b_addr = '0;
    logic [63:0] b_data = '0;
    logic [1:0]  b_size = '0;
    logic        b_mis;
    logic [31:0] b_bad;
    logic        b_mvalid;
    logic        b_mready = 1'b1;
    logic [31:0] b_maddr;
    logic [63:0] b_wdata;
    logic [7:0]  b_be;
    logic        b_empty;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    ent_t        q[$];
    logic        exp_mis = 1'b0;
    logic [31:0] exp_bad = '0;

    store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .st_size(st_size), .st_misalign(st_misalign), .st_bad_addr(st_bad_addr),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) u_dut64 (
        .clk(clk), .reset(reset),
        .st_valid(b_valid), .st_ready(b_ready), .st_addr(b_addr), .st_data(b_data),
        .st_size(b_size), .st_misalign(b_mis), .st_bad_addr(b_bad),
        .mem_valid(b_mvalid), .mem_ready(b_mready), .mem_addr(b_maddr),
        .mem_wdata(b_wdata), .mem_be(b_be), .sb_empty(b_empty), .sb_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference formatter: size in bytes, natural alignment, mask then shift.
    function automatic bit fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                               output ent_t e);
        int unsigned o;
        int unsigned n;
        logic [63:0] m;
        o = a % 4;
        case (sz)
            2'b10:   n = 1;
            2'b01:   n = 2;
            2'b00:   n = 4;
            default: n = 0;
        endcase
        e.addr = a & 32'hFFFF_FFFC;
        e.be   = '0;
        e.data = '0;
        if (n == 0 || (o % n) != 0) return 1'b1;
        e.be   = 4'(((1 << n) - 1) << o);
        m      = (64'd1 << (8 * n)) - 64'd1;
        e.data = 32'((64'(d) & m) << (8 * o));
        return 1'b0;
    endfunction

    function automatic bit hit(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        ent_t e;
        bit   mis;
        mis = fmt(a, d, sz, e);
        if (!MERGE || mis || q.size() < 2) return 1'b0;
        return q[q.size()-1].addr == e.addr;
    endfunction

    function automatic bit model_ready();
        return (q.size() < DEPTH) || hit(st_addr, st_data, st_size);
    endfunction

    // Advance one clock; the model applies the same edge's accept/retire decisions.
    task automatic cycle();
        ent_t e;
        ent_t y;
        bit   mis;
        bit   h;
        bit   acc;
        bit   deq;
        mis = fmt(st_addr, st_data, st_size, e);
        h   = hit(st_addr, st_data, st_size);
        acc = st_valid && ((q.size() < DEPTH) || h);
        deq = (q.size() != 0) && mem_ready;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (acc && !mis) begin
            if (h) begin
                y = q[q.size()-1];
                for (int i = 0; i < 4; i++) begin
                    if (e.be[i]) y.data[8*i +: 8] = e.data[8*i +: 8];
                end
                y.be = y.be | e.be;
                q[q.size()-1] = y;
            end else begin
                q.push_back(e);
            end
        end
        exp_mis = acc && mis;
        if (acc && mis) exp_bad = st_addr;
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " st_ready"}, 64'(st_ready), 64'd1);
        chk({tag, " mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, " sb_count"}, 64'(sb_count), 64'd0);
        chk({tag, " sb_empty"}, 64'(sb_empty), 64'd1);
        chk({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, " mem_be"}, 64'(mem_be), 64'd0);
        chk({tag, " st_misalign"}, 64'(st_misalign), 64'd0);
        chk({tag, " st_bad_addr"}, 64'(st_bad_addr), 64'd0);
    endtask

    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            chk("st_ready", 64'(st_ready), 64'(model_ready()));
            chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
            chk("sb_count", 64'(sb_count), 64'(q.size()));
            chk("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
            chk("st_misalign", 64'(st_misalign), 64'(exp_mis));
            chk("st_bad_addr", 64'(st_bad_addr), 64'(exp_bad));
            if (q.size() != 0) begin
                chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
                chk("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
                chk("mem_be", 64'(mem_be), 64'(q[0].be));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals("reset");
        chk("reset b_empty", 64'(b_empty), 64'd1);
        run_cmp = 1'b1;

        // Byte store lands on the top lane and retires one cycle later.
        mem_ready = 1'b1;
        put(32'h1003, 32'h0000_00AB, 2'b10);
        cycle();
        st_valid = 1'b0;
        chk("byte mem_addr", 64'(mem_addr), 64'h1000);
        chk("byte mem_wdata", 64'(mem_wdata), 64'hAB00_0000);
        chk("byte mem_be", 64'(mem_be), 64'h8);
        cycle();
        chk("byte retired", 64'(mem_valid), 64'd0);

        put(32'h2002, 32'h0000_1234, 2'b01);
        cycle();
        st_valid = 1'b0;
        chk("half mem_wdata", 64'(mem_wdata), 64'h1234_0000);
        chk("half mem_be", 64'(mem_be), 64'hC);
        cycle();

        put(32'h2001, 32'h0000_5678, 2'b01);
        cycle();
        st_valid = 1'b0;
        chk("half mis pulse", 64'(st_misalign), 64'd1);
        chk("half mis bad_addr", 64'(st_bad_addr), 64'h2001);
        chk("half mis count", 64'(sb_count), 64'd0);
        cycle();
        chk("mis pulse ends", 64'(st_misalign), 64'd0);
        chk("bad_addr held", 64'(st_bad_addr), 64'h2001);

        // Fill, then drain with overlapping enqueue.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h100 + 32'(4 * i), 32'(i + 1), 2'b00);
            cycle();
        end
        st_valid = 1'b0;
        chk("full st_ready", 64'(st_ready), 64'd0);
        chk("full count", 64'(sb_count), 64'd4);
        put(32'h200, 32'h99, 2'b00);
        mem_ready = 1'b1;
        cycle();
        chk("drain1 count", 64'(sb_count), 64'd3);
        chk("drain1 head", 64'(mem_addr), 64'h104);
        cycle();
        chk("enq+deq count", 64'(sb_count), 64'd3);
        chk("enq+deq head", 64'(mem_addr), 64'h108);
        st_valid = 1'b0;
        repeat (3) cycle();
        chk("drained empty", 64'(sb_empty), 64'd1);

        // Dword handling on both widths.
        put(32'h0, 32'h1234, 2'b11);
        b_valid = 1'b1; b_addr = 32'h08; b_data = 64'h1122_3344_5566_7788; b_size = 2'b11;
        cycle();
        st_valid = 1'b0; b_valid = 1'b0;
        chk("dw32 misalign", 64'(st_misalign), 64'd1);
        chk("dw64 valid", 64'(b_mvalid), 64'd1);
        chk("dw64 addr", 64'(b_maddr), 64'h08);
        chk("dw64 be", 64'(b_be), 64'hFF);
        chk("dw64 wdata", b_wdata, 64'h1122_3344_5566_7788);
        b_valid = 1'b1; b_addr = 32'h04; b_size = 2'b11;
        cycle();
        b_valid = 1'b0;
        chk("dw64 misalign", 64'(b_mis), 64'd1);
        chk("dw64 bad_addr", 64'(b_bad), 64'h04);
        chk("dw64 count", 64'(b_count), 64'd0);
        b_valid = 1'b1; b_addr = 32'h04; b_data = 64'hDEAD_BEEF; b_size = 2'b00;
        cycle();
        b_valid = 1'b0;
        chk("w64 be", 64'(b_be), 64'hF0);
        chk("w64 wdata", b_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("w64 addr", 64'(b_maddr), 64'h0);
        cycle();
        chk("w64 retired", 64'(b_mvalid), 64'd0);

        // Write combining behind a stalled head.
        mem_ready = 1'b0;
        put(32'h4000, 32'hCAFE, 2'b00);
        cycle();
        put(32'h3000, 32'h11, 2'b10);
        cycle();
        put(32'h3001, 32'h22, 2'b10);
        cycle();
        st_valid = 1'b0;
        chk("merge count", 64'(sb_count), MERGE ? 64'd2 : 64'd3);
        mem_ready = 1'b1;
        cycle();
        chk("merge head addr", 64'(mem_addr), 64'h3000);
        chk("merge head be", 64'(mem_be), MERGE ? 64'h3 : 64'h1);
        chk("merge head data", 64'(mem_wdata), MERGE ? 64'h2211 : 64'h11);
        repeat (2) cycle();

        // Reset mid-drain discards everything.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(32'h500 + 32'(4 * i), 32'(i + 7), 2'b00);
            cycle();
        end
        st_valid = 1'b0;
        chk("pre-reset count", 64'(sb_count), 64'd3);
        #2 reset = 1'b1;
        q.delete();
        exp_mis = 1'b0;
        exp_bad = '0;
        #1;
        check_reset_vals("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        put(32'h5000, 32'h55, 2'b00);
        cycle();
        st_valid = 1'b0;
        chk("post-reset count", 64'(sb_count), 64'd1);
        chk("post-reset addr", 64'(mem_addr), 64'h5000);
        chk("post-reset data", 64'(mem_wdata), 64'h55);
        mem_ready = 1'b1;
        cycle();

        for (int k = 0; k < 3000; k++) begin
            st_valid = ($urandom_range(0, 3) != 0);
            st_addr  = (($urandom_range(0, 3) == 0) ? 32'h7000 : 32'h3000) +
                       32'($urandom_range(0, 15));
            st_size  = 2'($urandom_range(0, 3));
            st_data  = $urandom;
            if (((k / 200) % 2) == 1) mem_ready = ($urandom_range(0, 3) == 0);
            else mem_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        st_valid  = 1'b0;
        mem_ready = 1'b1;
        repeat (6) cycle();
        chk("final empty", 64'(sb_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Parametrised store path between the MEM stage and data memory. Each accepted store has its data shifted onto the correct byte lanes, gets a byte-enable mask, and waits in a DEPTH-entry FIFO. A valid/ready handshake drains the FIFO into memory. This block replaces the combinational store-data formatter: it adds byte enables, a configurable bus width, misalignment detection, back-pressure, and optional write combining.

## Interface
- DATA_W, 32: memory data width. Legal values are 32 and 64. NB = DATA_W/8 byte lanes, OFS_W = log2(NB).
- ADDR_W, 32: byte-address width.
- DEPTH, 4: FIFO entries. Must be a power of two, ≥2.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high. Clears all state.
- st_valid  in  1  MEM stage presents a store.
- st_ready  out  1  store accepted this cycle when st_valid is also high.
- st_addr  in  ADDR_W  byte address.
- st_data  in  DATA_W  register data, right-justified.
- st_size  in  2  00 word, 01 half, 10 byte, 11 dword (DATA_W=64 only).
- st_misalign  out  1  registered one-cycle pulse: the last accepted store was misaligned or illegal.
- st_bad_addr  out  ADDR_W  address of that store. Held until the next pulse.
- mem_valid  out  1  FIFO head is valid.
- mem_ready  in  1  memory accepts the head.
- mem_addr  out  ADDR_W  head address with low OFS_W bits cleared.
- mem_wdata  out  DATA_W  lane-aligned data. Disabled lanes are zero.
- mem_be  out  NB  byte enables; bit i enables byte i.
- sb_empty  out  1  FIFO empty. Used by load/fence stall logic.
- sb_count  out  log2(DEPTH)+1  occupied entries.

## Operation
- Accept when st_valid && st_ready. st_ready = (sb_count != DEPTH), driven from registered state only. There is no combinational path from mem_ready.
- Offset: o = st_addr[OFS_W-1:0].
- Byte: be = 1<<o; data = st_data[7:0]<<(8*o).
- Half: requires o[0]=0. be = 2'b11<<o; data = st_data[15:0]<<(8*o).
- Word: requires o[1:0]=0. be = 4'hF<<o.
- Dword: requires o=0 and DATA_W=64. be = all ones.
- Misaligned or illegal size:
  - The store is still accepted, so the handshake completes.
  - No entry is written.
  - st_misalign pulses on the next cycle and st_bad_addr is loaded.
- Enqueue writes {aligned addr, data, be} at the tail. The tail pointer and count increment.
- Dequeue happens when mem_valid && mem_ready. The head pointer increments and count decrements.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Full vs empty is decided by sb_count.
- The FIFO is never bypassed. An entry becomes visible at the head no earlier than the cycle after it is enqueued.

## Timing
- Reset values: st_misalign 0, st_bad_addr 0, mem_valid 0, mem_addr 0, mem_wdata 0, mem_be 0, sb_empty 1, sb_count 0, st_ready 1. Pointers are 0.
- Latency, store accepted at edge N into an empty FIFO:
  - mem_valid is high after edge N.
  - With mem_ready held high, the entry retires at edge N+1.
- Throughput: one store per cycle in and one per cycle out.
- Head outputs are stable while mem_valid && !mem_ready.
- Reset mid-drain discards every entry. No partial write is retried.

## Configuration
- STORE_BUF_MERGE_EN defined: write combining is enabled.
  - Merge condition: the incoming aligned store has the same aligned address as the youngest entry, and that entry is not the head.
  - On merge, new bytes overwrite the youngest entry's data where the new be is set, and be |= new be.
  - No new entry is allocated, so count is unchanged.
  - A merge is allowed even when the FIFO is full. In that case st_ready = full && merge-hit, computed from registered tail state.
- Undefined: every aligned store allocates its own entry, and st_ready = !full.

## Structure
- store_buffer_pkg holds:
  - the size codes SZ_WORD, SZ_HALF, SZ_BYTE, SZ_DWORD;
  - the entry struct {addr, data, be};
  - a function returning the be mask for a given size and offset.
- Sub-module store_lane_align: the combinational formatter. Inputs are addr offset, size and data. Outputs are lane data, be and misalign. Parametrised by DATA_W.
- The FIFO, pointers, count and merge logic live in store_buffer.

## Test plan
- DATA_W=32, empty FIFO, mem_ready=1. Byte store addr 0x1003, data 0x000000AB → next cycle mem_addr 0x1000, mem_wdata 0xAB000000, mem_be 4'b1000; retires one cycle later.
- Half store addr 0x2002, data 0x1234 → mem_wdata 0x12340000, mem_be 4'b1100. Half store at 0x2001 → st_misalign pulse, st_bad_addr 0x2001, sb_count stays 0.
- mem_ready=0, DEPTH=4, four aligned word stores:
  - st_ready drops after the fourth.
  - Raising mem_ready drains them in order, one per cycle.
  - Enqueue and dequeue in the same cycle keep sb_count constant.
- DATA_W=64. Dword store addr 0x08 → be 8'hFF. Dword store at 0x04 → misalign. With DATA_W=32, size 11 → misalign.
- STORE_BUF_MERGE_EN, mem_ready=0, one entry already at the head:
  - Byte stores to 0x3000 then 0x3001 produce one entry with be 4'b0011; sb_count goes to 2, not 3.
  - Without the macro, sb_count goes to 3.
- Assert reset with 3 entries queued and mem_valid high → all outputs return to their reset values; the next store after release enqueues normally.
